idu_imm_seq: RTL and testbench

Decode-stage sequencer that sits between the instruction fetch unit and the immediate generator. It accepts one instruction per valid/ready handshake and classifies its opcode into an immediate type. It drives the immediate generator with a registered instruction and type, captures the returned immediate, and presents a registered decode bundle to the execute stage under a second valid/ready handshake.

---
 rtl/idu_imm_seq.sv | 205 ++++++++++++++++++++
 tb/tb_idu_imm_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_imm_seq.sv
// Decode-stage sequencer: fetch handshake -> immediate generator -> registered decode bundle.
// Optional IDU_ILLEGAL_CHECK_EN adds the out_illegal flag and zeroes out_imm for unsupported opcodes.
module idu_imm_seq #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  input  logic             flush,
  output logic [2:0]       ig_itype,
  output logic [31:0]      ig_inst,
  input  logic [31:0]      ig_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_itype,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
`ifdef IDU_ILLEGAL_CHECK_EN
  output logic             out_illegal,
`endif
  output logic [CNT_W-1:0] dec_cnt
);

  typedef enum logic [2:0] {
    IT_NULL = 3'd0,
    IT_I    = 3'd1,
    IT_U    = 3'd2,
    IT_J    = 3'd3,
    IT_S    = 3'd4,
    IT_B    = 3'd5
  } itype_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_OUT
  } state_e;

  function automatic itype_e itype_of(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111:                         itype_of = IT_U;
      7'b1101111:                                     itype_of = IT_J;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: itype_of = IT_I;
      7'b0100011:                                     itype_of = IT_S;
      7'b1100011:                                     itype_of = IT_B;
      default:                                        itype_of = IT_NULL;
    endcase
  endfunction

`ifdef IDU_ILLEGAL_CHECK_EN
  function automatic logic is_illegal(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
      7'b0010011, 7'b1110011, 7'b0100011, 7'b1100011, 7'b0110011:
        is_illegal = 1'b0;
      default:
        is_illegal = 1'b1;
    endcase
  endfunction
`endif

  state_e           state_q, state_d;
  itype_e           ig_itype_q, ig_itype_d;
  logic [31:0]      ig_inst_q, ig_inst_d;
  logic [31:0]      out_imm_q, out_imm_d;
  itype_e           out_itype_q, out_itype_d;
  logic [6:0]       out_opcode_q, out_opcode_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic [4:0]       out_rs1_q, out_rs1_d;
  logic [4:0]       out_rs2_q, out_rs2_d;
  logic [2:0]       out_funct3_q, out_funct3_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [31:0]      b_imm;
  logic [31:0]      imm_sel;
`ifdef IDU_ILLEGAL_CHECK_EN
  logic             out_illegal_q, out_illegal_d;
  logic             eval_illegal;
`endif

  // The generator does not handle B; that immediate is assembled here.
  assign b_imm = {{20{ig_inst_q[31]}}, ig_inst_q[7], ig_inst_q[30:25], ig_inst_q[11:8], 1'b0};

  always_comb begin
    imm_sel = (ig_itype_q == IT_B) ? b_imm : ig_imm;
`ifdef IDU_ILLEGAL_CHECK_EN
    eval_illegal = is_illegal(ig_inst_q[6:0]);
    if (eval_illegal) begin
      imm_sel = '0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    ig_itype_d   = ig_itype_q;
    ig_inst_d    = ig_inst_q;
    out_imm_d    = out_imm_q;
    out_itype_d  = out_itype_q;
    out_opcode_d = out_opcode_q;
    out_rd_d     = out_rd_q;
    out_rs1_d    = out_rs1_q;
    out_rs2_d    = out_rs2_q;
    out_funct3_d = out_funct3_q;
    dec_cnt_d    = dec_cnt_q;
`ifdef IDU_ILLEGAL_CHECK_EN
    out_illegal_d = out_illegal_q;
`endif

    // Flush gates in_ready, so an accept below can never coincide with a flush.
    in_ready  = !flush && ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
    out_valid = (state_q == S_OUT);

    if (in_valid && in_ready) begin
      ig_inst_d  = in_inst;
      ig_itype_d = itype_of(in_inst[6:0]);
    end

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          out_imm_d    = imm_sel;
          out_itype_d  = ig_itype_q;
          out_opcode_d = ig_inst_q[6:0];
          out_rd_d     = ig_inst_q[11:7];
          out_funct3_d = ig_inst_q[14:12];
          out_rs1_d    = ig_inst_q[19:15];
          out_rs2_d    = ig_inst_q[24:20];
`ifdef IDU_ILLEGAL_CHECK_EN
          out_illegal_d = eval_illegal;
`endif
          state_d = S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            dec_cnt_d = dec_cnt_q + CNT_W'(1);
            state_d   = in_valid ? S_EVAL : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ig_itype_q   <= IT_NULL;
      ig_inst_q    <= '0;
      out_imm_q    <= '0;
      out_itype_q  <= IT_NULL;
      out_opcode_q <= '0;
      out_rd_q     <= '0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_funct3_q <= '0;
      dec_cnt_q    <= '0;
`ifdef IDU_ILLEGAL_CHECK_EN
      out_illegal_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ig_itype_q   <= ig_itype_d;
      ig_inst_q    <= ig_inst_d;
      out_imm_q    <= out_imm_d;
      out_itype_q  <= out_itype_d;
      out_opcode_q <= out_opcode_d;
      out_rd_q     <= out_rd_d;
      out_rs1_q    <= out_rs1_d;
      out_rs2_q    <= out_rs2_d;
      out_funct3_q <= out_funct3_d;
      dec_cnt_q    <= dec_cnt_d;
`ifdef IDU_ILLEGAL_CHECK_EN
      out_illegal_q <= out_illegal_d;
`endif
    end
  end

  assign ig_itype   = ig_itype_q;
  assign ig_inst    = ig_inst_q;
  assign out_imm    = out_imm_q;
  assign out_itype  = out_itype_q;
  assign out_opcode = out_opcode_q;
  assign out_rd     = out_rd_q;
  assign out_rs1    = out_rs1_q;
  assign out_rs2    = out_rs2_q;
  assign out_funct3 = out_funct3_q;
  assign dec_cnt    = dec_cnt_q;
`ifdef IDU_ILLEGAL_CHECK_EN
  assign out_illegal = out_illegal_q;
`endif

endmodule

// File: tb/tb_idu_imm_seq.sv
// Testbench for idu_imm_seq: vector table through a scoreboard plus hand-built corner sequences.
module tb_idu_imm_seq;

  localparam logic [31:0] NULL_IMM = 32'h5A5A_5A5A;
`ifdef IDU_ILLEGAL_CHECK_EN
  localparam logic [31:0] ILL_IMM  = 32'h0000_0000;
  localparam logic        ILL_FLAG = 1'b1;
`else
  localparam logic [31:0] ILL_IMM  = NULL_IMM;
  localparam logic        ILL_FLAG = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        flush;
  logic [2:0]  ig_itype;
  logic [31:0] ig_inst;
  logic [31:0] ig_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_itype;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic        ill_act;
  logic [3:0]  dec_cnt;

  idu_imm_seq #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_ready   (in_ready),
    .flush      (flush),
    .ig_itype   (ig_itype),
    .ig_inst    (ig_inst),
    .ig_imm     (ig_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_itype  (out_itype),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_funct3 (out_funct3),
`ifdef IDU_ILLEGAL_CHECK_EN
    .out_illegal(ill_act),
`endif
    .dec_cnt    (dec_cnt)
  );

`ifndef IDU_ILLEGAL_CHECK_EN
  assign ill_act = 1'b0;
`endif

  // Immediate generator model; B returns poison since the DUT must build it itself.
  function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd1:    gen_imm = {{20{i[31]}}, i[31:20]};
      3'd2:    gen_imm = {i[31:12], 12'h000};
      3'd3:    gen_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd5:    gen_imm = 32'hDEAD_BEEF;
      default: gen_imm = NULL_IMM;
    endcase
  endfunction

  assign ig_imm = gen_imm(ig_inst, ig_itype);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  itype;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];
  vec_t sb [$];
  vec_t cur_exp;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   last_ho = -1;
  logic thru = 1'b0;
  logic [3:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [60:0] act_bundle();
    return {out_itype, out_imm, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, ill_act};
  endfunction

  function automatic logic [60:0] exp_bundle(input vec_t e);
    logic [31:0] w;
    w = e.inst;
    return {e.itype, e.imm, w[6:0], e.rd, e.rs1, e.rs2, e.f3, e.ill};
  endfunction

  // Monitor/scoreboard: push on accept, pop and compare on hand-off.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        exp_cnt = '0;
        last_ho = -1;
      end else if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("handoff_without_accept", 64'(out_valid), 64'(1'b0));
          end else begin
            e = sb.pop_front();
            chk("bundle", 64'(act_bundle()), 64'(exp_bundle(e)));
          end
          chk("dec_cnt", 64'(dec_cnt), 64'(exp_cnt));
          exp_cnt = exp_cnt + 4'd1;
          if (thru && last_ho >= 0) chk("handoff_gap", 64'(cyc - last_ho), 64'(2));
          last_ho = cyc;
        end
        if (in_valid && in_ready) sb.push_back(cur_exp);
      end
    end
  end

  task automatic send(input int i, input logic rnd);
    logic acc;
    acc = 1'b0;
    cur_exp  = vec[i];
    in_inst  = vec[i].inst;
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accept_timeout", 64'(acc), 64'(1'b1));
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !out_valid;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 64'(done), 64'(1'b1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1'b1));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
    chk({tag, "_ig"},        64'({ig_itype, ig_inst}), 64'(0));
    chk({tag, "_bundle"},    64'(act_bundle()), 64'(0));
    chk({tag, "_dec_cnt"},   64'(dec_cnt),   64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h123450B7, 3'd2, 32'h12345000, 5'd1,  5'd8,  5'd3,  3'd5, 1'b0};
    vec[1] = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 5'd1,  5'd0,  5'd31, 3'd0, 1'b0};
    vec[2] = '{32'hFE112E23, 3'd4, 32'hFFFFFFFC, 5'd28, 5'd2,  5'd1,  3'd2, 1'b0};
    vec[3] = '{32'hFE0008E3, 3'd5, 32'hFFFFFFF0, 5'd17, 5'd0,  5'd0,  3'd0, 1'b0};
    vec[4] = '{32'h008000EF, 3'd3, 32'h00000008, 5'd1,  5'd0,  5'd8,  3'd0, 1'b0};
    vec[5] = '{32'h002081B3, 3'd0, NULL_IMM,     5'd3,  5'd1,  5'd2,  3'd0, 1'b0};
    vec[6] = '{32'h00412283, 3'd1, 32'h00000004, 5'd5,  5'd2,  5'd4,  3'd2, 1'b0};
    vec[7] = '{32'hFFFFF117, 3'd2, 32'hFFFFF000, 5'd2,  5'd31, 5'd31, 3'd7, 1'b0};
    vec[8] = '{32'h00008067, 3'd1, 32'h00000000, 5'd0,  5'd1,  5'd0,  3'd0, 1'b0};
    vec[9] = '{32'h0000007F, 3'd0, ILL_IMM,      5'd0,  5'd0,  5'd0,  3'd0, ILL_FLAG};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0; flush = 1'b0;
    cur_exp = vec[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // U-type: latency two edges, then hand-off bumps dec_cnt
    cur_exp = vec[0]; in_inst = vec[0].inst; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("u_eval_out_valid", 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    chk("u_out_valid", 64'(out_valid), 64'(1'b1));
    chk("u_itype",     64'(out_itype), 64'(3'd2));
    chk("u_imm",       64'(out_imm),   64'(32'h12345000));
    chk("u_rd",        64'(out_rd),    64'(5'd1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("u_dec_cnt",   64'(dec_cnt),   64'(4'd1));
    chk("u_idle",      64'(out_valid), 64'(1'b0));

    // I-type under 5 cycles of backpressure with a competing fetch request
    @(posedge clk); #1;
    cur_exp = vec[1]; in_inst = vec[1].inst; in_valid = 1'b1;
    @(posedge clk); #1;
    cur_exp = vec[5]; in_inst = vec[5].inst;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
      chk("bp_in_ready",  64'(in_ready),  64'(1'b0));
      chk("bp_imm",       64'({out_itype, out_imm}), 64'({3'd1, 32'hFFFFFFFF}));
      chk("bp_ig_inst",   64'(ig_inst),   64'(32'hFFF00093));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    drain();
    @(negedge clk);
    chk("bp_dec_cnt", 64'(dec_cnt), 64'(4'd3));
    @(posedge clk); #1;

    // Back-to-back stream: one bundle every 2 cycles
    thru = 1'b1; last_ho = -1; out_ready = 1'b1;
    for (int i = 0; i < NV; i++) send(i, 1'b0);
    drain();
    thru = 1'b0;
    @(negedge clk);
    chk("b2b_dec_cnt", 64'(dec_cnt), 64'(4'd13));
    @(posedge clk); #1;

    // Random out_ready; counter wraps past 15
    for (int i = 0; i < NV; i++) send(i, 1'b1);
    drain();
    @(negedge clk);
    chk("rnd_dec_cnt_wrap", 64'(dec_cnt), 64'(4'd7));
    @(posedge clk); #1;

    // Flush in OUT while a hand-off and a new accept are both offered
    out_ready = 1'b0;
    send(2, 1'b0);
    cur_exp = vec[0]; in_inst = vec[0].inst;
    @(posedge clk); #1;
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready",  64'(in_ready),  64'(1'b0));
    chk("fl_out_valid", 64'(out_valid), 64'(1'b1));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("fl_dropped",   64'(out_valid), 64'(1'b0));
    chk("fl_dec_cnt",   64'(dec_cnt),   64'(4'd7));
    chk("fl_ig_inst",   64'(ig_inst),   64'(32'hFE112E23));
    chk("fl_imm_kept",  64'(out_imm),   64'(32'hFFFFFFFC));
    chk("fl_idle",      64'(in_ready),  64'(1'b1));
    @(posedge clk); #1;

    // Async reset between edges while in EVAL
    send(1, 1'b0);
    in_valid = 1'b0;
    chk("ar_pre_ig", 64'(ig_inst), 64'(32'hFFF00093));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_after", 64'(out_valid), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
